// File: rtl/priority_encoder4to2_seq.sv
// Registered 4-to-2 priority encoder: latches request lines and presents them
// one at a time as a binary index under a valid/ack handshake.
module priority_encoder4to2_seq #(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [1:0] y,
  output logic       valid,
  output logic [3:0] pending,
  output logic       ovf
);

  // state   | meaning
  // IDLE    | nothing presented; arbitrate pending on the next edge
  // PRESENT | y holds a pending index, valid=1, waiting for ack
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] set_req;
  logic [3:0] clr;
  logic [3:0] pending_nxt;
  logic       ovf_hit;

  function automatic logic [1:0] winner(input logic [3:0] p);
    logic [1:0] w;
    w = 2'd0;
    if (HI_FIRST) begin
      if (p[3])      w = 2'd3;
      else if (p[2]) w = 2'd2;
      else if (p[1]) w = 2'd1;
      else           w = 2'd0;
    end else begin
      if (p[0])      w = 2'd0;
      else if (p[1]) w = 2'd1;
      else if (p[2]) w = 2'd2;
      else           w = 2'd3;
    end
    return w;
  endfunction

  // A set on the same edge as the clear wins, so a re-request is never lost.
  always_comb begin
    set_req     = 4'b0000;
    clr         = 4'b0000;
    pending_nxt = pending;
    ovf_hit     = 1'b0;
    if (E) set_req = req;
    if (valid && ack) clr = 4'b0001 << y;
    pending_nxt = (pending & ~clr) | set_req;
    ovf_hit     = |(set_req & pending & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      y       <= 2'b00;
      valid   <= 1'b0;
      pending <= 4'b0000;
      ovf     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (ovf_hit) ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (pending != 4'b0000) begin
            state <= PRESENT;
            y     <= winner(pending);
            valid <= 1'b1;
          end
        end
        PRESENT: begin
          // y stays frozen until ack even if a higher-priority bit latches
          if (ack) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
